bpc_block_packer: RTL and testbench

//  Downstream of the BPC code buffer. Captures the 64-bit code words (d_valid) and the

---
 rtl/bpc_pkg.sv | 24 ++
 rtl/bpc_block_packer_if.sv | 14 +
 rtl/bpc_slot_mem.sv | 27 ++
 rtl/bpc_block_packer.sv | 149 ++++++++++++++
 tb/tb_bpc_block_packer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bpc_pkg.sv
// Shared widths, header layout and FSM states for the BPC block packer.
// Header beat layout is fixed at 16 bits: {raw, nwords[3:0], size[10:0]}.
package bpc_pkg;

  localparam int BPC_DW         = 64;
  localparam int BPC_SW         = 11;
  localparam int BPC_MAX_WORDS  = 8;
  localparam int BPC_NSLOT      = 2;
  localparam int BPC_RAW_THRESH = 512;
  localparam int BPC_CW         = $clog2(BPC_MAX_WORDS + 1);

  typedef struct packed {
    logic              raw;
    logic [BPC_CW-1:0] nwords;
    logic [BPC_SW-1:0] size;
  } bpc_hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } pk_state_e;

endpackage

// File: rtl/bpc_block_packer_if.sv
// Valid/ready beat stream carrying header and data beats of packed blocks.
// The master holds data/hdr/last stable while valid is high and ready is low.
interface bpc_block_packer_if #(
  parameter int DW = 64
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          hdr;
  logic          last;

  modport master (output data, valid, hdr, last, input ready);
  modport slave  (input data, valid, hdr, last, output ready);
endinterface

// File: rtl/bpc_slot_mem.sv
// Flop array for all block slots, addressed {slot, word}: one write port,
// one combinational read port (read data visible in the same cycle).
module bpc_slot_mem #(
  parameter int DW        = 64,
  parameter int NSLOT     = 2,
  parameter int MAX_WORDS = 8,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NSLOT*MAX_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bpc_block_packer.sv
// Packs code-buffer words into a ring of block slots and streams each as header + words.
// Header valid one cycle after the commit is seen; input never stalls, drops set overflow_o.
module bpc_block_packer
  import bpc_pkg::*;
#(
  parameter int DW        = BPC_DW,
  parameter int SW        = BPC_SW,
  parameter int MAX_WORDS = BPC_MAX_WORDS,
  parameter int NSLOT     = BPC_NSLOT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            data_i,
  input  logic                     d_valid_i,
  input  logic [SW-1:0]            size_i,
  input  logic                     s_valid_i,
  bpc_block_packer_if.master       m,
  output logic                     overflow_o,
  output logic                     busy_o
);

  localparam int CW  = $clog2(MAX_WORDS + 1);
  localparam int WAW = $clog2(MAX_WORDS);
  localparam int PW  = $clog2(NSLOT);
  localparam int OW  = $clog2(NSLOT + 1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] wcnt, rcnt, rcnt_n;
  logic          bad;
  bpc_hdr_t      meta [NSLOT];
  bpc_hdr_t      cur;
  pk_state_e     state, state_n;

  logic          full, wr_en, word_drop, commit, blk_drop, rel, last_beat;
  logic [CW-1:0] nwords_c;
  logic [DW-1:0] rd_word;

  assign full      = (occ == OW'(NSLOT));
  assign wr_en     = d_valid_i && !full && (wcnt != CW'(MAX_WORDS));
  assign word_drop = d_valid_i && !wr_en;
  // A block that lost any word to a full ring is discarded whole at its commit.
  assign commit    = s_valid_i && !full && !bad;
  assign blk_drop  = s_valid_i && !commit;
  assign nwords_c  = wcnt + CW'(wr_en);

  assign cur       = meta[rd_ptr];
  assign last_beat = (rcnt == cur.nwords - 1'b1);

  bpc_slot_mem #(
    .DW        (DW),
    .NSLOT     (NSLOT),
    .MAX_WORDS (MAX_WORDS),
    .AW        (PW + WAW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_ptr, wcnt[WAW-1:0]}),
    .wdata (data_i),
    .raddr ({rd_ptr, rcnt[WAW-1:0]}),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    rel     = 1'b0;
    m.valid = 1'b0;
    m.hdr   = 1'b0;
    m.last  = 1'b0;
    m.data  = '0;
    case (state)
      IDLE: begin
        if (occ != '0) state_n = HDR;
      end
      HDR: begin
        m.valid = 1'b1;
        m.hdr   = 1'b1;
        m.last  = (cur.nwords == '0);
        m.data  = {{(DW-$bits(bpc_hdr_t)){1'b0}}, cur};
        if (m.ready) begin
          if (cur.nwords != '0) begin
            state_n = DATA;
            rcnt_n  = '0;
          end else begin
            rel = 1'b1;
          end
        end
      end
      DATA: begin
        m.valid = 1'b1;
        m.last  = last_beat;
        m.data  = rd_word;
        if (m.ready) begin
          rcnt_n = rcnt + 1'b1;
          if (last_beat) rel = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Go straight to the next header when another slot is already waiting.
    if (rel) begin
      rcnt_n  = '0;
      state_n = (occ > OW'(1)) ? HDR : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      wcnt       <= '0;
      bad        <= 1'b0;
      overflow_o <= 1'b0;
      for (int i = 0; i < NSLOT; i++) meta[i] <= '0;
    end else begin
      if (word_drop || blk_drop) overflow_o <= 1'b1;
      if (s_valid_i) begin
        wcnt <= '0;
        bad  <= 1'b0;
      end else begin
        if (wr_en) wcnt <= wcnt + 1'b1;
        if (d_valid_i && full) bad <= 1'b1;
      end
      if (commit) begin
        meta[wr_ptr].raw    <= (size_i >= SW'(BPC_RAW_THRESH));
        meta[wr_ptr].nwords <= nwords_c;
        meta[wr_ptr].size   <= size_i;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rel) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(commit) - OW'(rel);
    end
  end

  assign busy_o = (occ != '0) || (wcnt != '0) || m.valid;

endmodule

// File: tb/tb_bpc_block_packer.sv
// Directed bench for bpc_block_packer: per-cycle vector table plus hand sequences
// for backpressure/overflow, reset mid-block and the raw/oversize block.
module tb_bpc_block_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_i;
  logic        d_valid_i;
  logic [10:0] size_i;
  logic        s_valid_i;
  logic        overflow_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  bpc_block_packer_if #(.DW(64)) m_if ();

  bpc_block_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .d_valid_i  (d_valid_i),
    .size_i     (size_i),
    .s_valid_i  (s_valid_i),
    .m          (m_if.master),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [63:0] d;
    logic        sv;
    logic [10:0] sz;
    logic        rdy;
    logic        ev;
    logic        eh;
    logic        el;
    logic [63:0] ed;
    logic        eo;
    logic        eb;
  } vec_t;

  vec_t vt[$];

  function automatic logic [63:0] w(input logic [7:0] tag, input int k);
    return {tag, 56'(k)};
  endfunction

  function automatic void add(input logic dv, input logic [63:0] d, input logic sv,
                              input logic [10:0] sz, input logic rdy, input logic ev,
                              input logic eh, input logic el, input logic [63:0] ed,
                              input logic eo, input logic eb);
    vec_t v;
    v.dv = dv; v.d = d; v.sv = sv; v.sz = sz; v.rdy = rdy;
    v.ev = ev; v.eh = eh; v.el = el; v.ed = ed; v.eo = eo; v.eb = eb;
    vt.push_back(v);
  endfunction

  task automatic step(input logic dv, input logic [63:0] d, input logic sv,
                      input logic [10:0] sz, input logic rdy);
    d_valid_i  = dv;
    data_i     = d;
    s_valid_i  = sv;
    size_i     = sz;
    m_if.ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input logic [63:0] d, input logic h, input logic l);
    chk({nm, " valid"}, 64'(m_if.valid), 64'(1));
    chk({nm, " data"},  m_if.data, d);
    chk({nm, " hdr"},   64'(m_if.hdr), 64'(h));
    chk({nm, " last"},  64'(m_if.last), 64'(l));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " valid"}, 64'(m_if.valid), 64'(0));
    chk({nm, " busy"},  64'(busy_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_d [5];
    logic        exp_h [5];
    logic        exp_l [5];

    // Block 1: eight words, size 500 -> header 0x41F4
    for (int k = 0; k < 8; k++) add(1, w(8'hA0, k), 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 11'd500, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 0, 64'h41F4, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 1, 1, 0, (k == 7), w(8'hA0, k), 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Block 2: third word arrives together with the commit, size 150 -> 0x1896
    add(1, w(8'hB0, 0), 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, w(8'hB0, 1), 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, w(8'hB0, 2), 1, 11'd150, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 0, 64'h1896, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 1, 0, (k == 2), w(8'hB0, k), 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Block 3: empty block is a single header beat marked last
    add(0, 0, 1, 11'd0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 1, 64'h0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0; d_valid_i = 0; data_i = 0; s_valid_i = 0; size_i = 0; m_if.ready = 0;
    #12;
    chk("reset valid",    64'(m_if.valid), 64'(0));
    chk("reset hdr",      64'(m_if.hdr),   64'(0));
    chk("reset last",     64'(m_if.last),  64'(0));
    chk("reset data",     m_if.data,       64'(0));
    chk("reset overflow", 64'(overflow_o), 64'(0));
    chk("reset busy",     64'(busy_o),     64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].dv, vt[i].d, vt[i].sv, vt[i].sz, vt[i].rdy);
      chk($sformatf("vec%0d valid", i), 64'(m_if.valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d data", i), m_if.data, vt[i].ed);
        chk($sformatf("vec%0d hdr", i),  64'(m_if.hdr),  64'(vt[i].eh));
        chk($sformatf("vec%0d last", i), 64'(m_if.last), 64'(vt[i].el));
      end
      chk($sformatf("vec%0d overflow", i), 64'(overflow_o), 64'(vt[i].eo));
      chk($sformatf("vec%0d busy", i),     64'(busy_o),     64'(vt[i].eb));
    end

    // Backpressure: two blocks fill the ring, a third is dropped, header held stable.
    for (int c = 0; c < 20; c++) begin
      case (c)
        0: step(1, w(8'h11, 0), 0, 0, 0);
        1: step(1, w(8'h11, 1), 0, 0, 0);
        2: step(0, 0, 1, 11'd100, 0);
        4: step(1, w(8'h22, 0), 0, 0, 0);
        5: step(0, 0, 1, 11'd64, 0);
        6: step(1, w(8'h33, 0), 0, 0, 0);
        7: step(0, 0, 1, 11'd10, 0);
        default: step(0, 0, 0, 0, 0);
      endcase
      if (c >= 3) chk_beat($sformatf("stall%0d", c), 64'h1064, 1, 0);
      chk($sformatf("stall%0d overflow", c), 64'(overflow_o), 64'(c >= 6));
    end
    exp_d[0] = 64'h1064;      exp_h[0] = 1; exp_l[0] = 0;
    exp_d[1] = w(8'h11, 0);   exp_h[1] = 0; exp_l[1] = 0;
    exp_d[2] = w(8'h11, 1);   exp_h[2] = 0; exp_l[2] = 1;
    exp_d[3] = 64'h0840;      exp_h[3] = 1; exp_l[3] = 0;
    exp_d[4] = w(8'h22, 0);   exp_h[4] = 0; exp_l[4] = 1;
    for (int b = 0; b < 5; b++) begin
      chk_beat($sformatf("drain%0d", b), exp_d[b], exp_h[b], exp_l[b]);
      step(0, 0, 0, 0, 1);
    end
    chk_idle("drain end");
    chk("drain overflow sticky", 64'(overflow_o), 64'(1));

    // Reset in the middle of a data phase.
    step(1, w(8'hD0, 0), 0, 0, 1);
    step(1, w(8'hD0, 1), 0, 0, 1);
    step(1, w(8'hD0, 2), 1, 11'd200, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_beat("pre-reset", w(8'hD0, 0), 0, 0);
    rst_n = 1'b0;
    #2;
    chk("rst async valid",    64'(m_if.valid), 64'(0));
    chk("rst async overflow", 64'(overflow_o), 64'(0));
    @(posedge clk);
    #1;
    chk_idle("rst next");
    chk("rst next overflow", 64'(overflow_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1, w(8'hE0, 0), 0, 0, 1);
    step(0, 0, 1, 11'd40, 1);
    chk("post-rst commit valid", 64'(m_if.valid), 64'(0));
    step(0, 0, 0, 0, 1);
    chk_beat("post-rst hdr", 64'h0828, 1, 0);
    step(0, 0, 0, 0, 1);
    chk_beat("post-rst word", w(8'hE0, 0), 0, 1);
    step(0, 0, 0, 0, 1);
    chk_idle("post-rst end");

    // Raw block (size 652) with a ninth word that must be dropped.
    for (int k = 0; k < 8; k++) step(1, w(8'hC0, k), 0, 0, 1);
    chk("raw 8 words overflow", 64'(overflow_o), 64'(0));
    step(1, w(8'hC0, 8), 0, 0, 1);
    chk("raw 9th word overflow", 64'(overflow_o), 64'(1));
    step(0, 0, 1, 11'd652, 1);
    step(0, 0, 0, 0, 1);
    chk_beat("raw hdr", 64'hC28C, 1, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0, 1);
      chk_beat($sformatf("raw word%0d", k), w(8'hC0, k), 0, (k == 7));
    end
    step(0, 0, 0, 0, 1);
    chk_idle("raw end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
